lsu_mem_sequencer: RTL
======================

# lsu_mem_sequencer

Sequences scalar and vector load/store transactions from the RV32I execute stage onto the single-port data-memory bus. It takes the 3-bit width code produced by the load/store width decoder, along with address and store data. It issues one or more word-wide bus beats with byte enables, then returns a sign- or zero-extended scalar result or a gathered vector result. At most one transaction is in flight at a time.

## Interface
- `VLANES`, 4: 32-bit lanes per vector transaction; legal range 1..8.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid` input 1: execute stage presents a transaction.
- `req_ready` output 1: sequencer can accept a transaction; high only in IDLE.
- `req_store` input 1: 1 = store, 0 = load.
- `req_width` input 3: width code. 0 = byte signed, 1 = half signed, 2 = word, 3 = byte unsigned, 4 = half unsigned, 5 = vector, 6/7 = reserved.
- `req_addr` input 32: byte address; for vector, the base address of lane 0.
- `req_wdata` input 32: scalar store data in the low bits.
- `req_vwdata` input 32*VLANES: vector store data; lane i is at bits [32i+31:32i].
- `mem_req` output 1: bus request.
- `mem_we` output 1: write strobe.
- `mem_addr` output 32: word-aligned bus address; bits [1:0] are always 0.
- `mem_be` output 4: byte enables.
- `mem_wdata` output 32: lane-shifted write data.
- `mem_gnt` input 1: bus accepted the current beat.
- `mem_rvalid` input 1: beat completed; returned for both loads and stores.
- `mem_rdata` input 32: read data; valid when `mem_rvalid` is high.
- `resp_valid` output 1: one-cycle completion pulse.
- `resp_err` output 1: qualifies `resp_valid`; the transaction was rejected.
- `resp_rdata` output 32: extended scalar load result.
- `resp_vrdata` output 32*VLANES: gathered vector load result.

## Operation
- FSM states:
  - IDLE → ISSUE on handshake `req_valid && req_ready`. The sequencer latches store flag, width, address and data, and clears the beat counter.
  - IDLE → RESP with `resp_err`=1 on a reserved width, and on a misaligned access when the macro is enabled. No bus beat is issued.
  - ISSUE: `mem_req`=1. Stays in ISSUE until `mem_gnt`, then moves to WAIT.
  - WAIT: `mem_req`=0. On `mem_rvalid`, the sequencer stores the lane data for loads. It then goes to ISSUE if beats remain, otherwise to RESP.
  - RESP: `resp_valid`=1 for exactly one cycle, then back to IDLE. There is no response backpressure.
- Beats per transaction:
  - Scalar: 1.
  - Vector: VLANES beats. Beat k uses address `{base[31:2],2'b00} + 4k`, `mem_be`=4'b1111, and `mem_wdata` = lane k.
- Scalar byte lane is addr[1:0].
  - Byte access: `mem_be` = 1 << addr[1:0]; `mem_wdata` = {4{wdata[7:0]}}.
  - Half access: `mem_be` = 4'b0011 << {addr[1],1'b0}; `mem_wdata` = {2{wdata[15:0]}}.
  - Word access: `mem_be`=4'b1111.
- Load extraction:
  - The byte or half is selected by addr[1:0].
  - Codes 0 and 1 sign-extend; codes 3 and 4 zero-extend; code 2 passes the word through.
- Addresses wrap modulo 2^32 across vector beats.
- Outputs during a transaction:
  - `resp_rdata` and `resp_vrdata` hold their last values until the next load completes.
  - Vector stores leave `resp_vrdata` unchanged.
- `mem_rvalid` outside WAIT is ignored. `mem_gnt` outside ISSUE is ignored.
- Reset, whether idle or mid-transaction, is immediate:
  - State returns to IDLE and the in-flight transaction is abandoned with no response.
  - All outputs go to 0 except `req_ready`, which is 1 once `rst` deasserts.
  - Both result registers return to 0.

## Timing
- Accept at edge T → `mem_req` high in cycle T+1.
- Zero-wait bus (`mem_gnt` in ISSUE's first cycle, `mem_rvalid` one cycle later): a scalar transaction shows `resp_valid` at T+3.
- Each vector beat costs 2 cycles plus bus stalls. `resp_valid` arrives at T+1+2·VLANES.
- `req_ready` falls in the cycle after acceptance and rises the cycle after RESP, so back-to-back accepts are 4 cycles apart minimum.
- Error responses: `resp_valid` with `resp_err` at T+1.
- All outputs are registered, with no combinational path from `mem_*` inputs to `mem_*` outputs.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A half access with addr[0]=1, a word access with addr[1:0]≠0, or a vector access with addr[1:0]≠0 produces an error response with no bus activity.
- Undefined:
  - The misaligned low address bits are ignored.
  - A half access uses the half selected by addr[1].
  - Word and vector accesses use `{addr[31:2],2'b00}`.
  - `resp_err` is asserted only for reserved widths.

## Test plan
- Load byte signed, addr 0x1003, `mem_rdata`=0x80FF_FF12 → `mem_be`=4'b1000, `resp_rdata`=0xFFFF_FF80, `resp_valid` at T+3 with zero-wait bus.
- Store half, addr 0x2002, wdata 0x0000_BEEF → `mem_be`=4'b1100, `mem_wdata`=0xBEEF_BEEF, `mem_addr`=0x2000.
- Vector load (VLANES=4) at base 0x3000, `mem_gnt` delayed 2 cycles on beat 1 → four beats at 0x3000/4/8/C, all lanes gathered in order, `resp_valid` once, at T+11.
- Vector store at base 0xFFFF_FFF8 → addresses FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Width 6, then word at 0x4001 → the reserved width gives `resp_err` at T+1 with no `mem_req`. The 0x4001 word errors if the macro is defined, else it accesses 0x4000.
- `rst` pulsed while in WAIT of beat 2 → `mem_req`=0, `resp_valid` never fires, next request proceeds normally.

Source files
------------

// File: rtl/lsu_mem_sequencer.sv
// lsu_mem_sequencer: moves RV32I scalar and vector load/store transactions
// onto the single-port data-memory bus, one transaction at a time.
// Scalar accesses take one bus beat. Vector accesses take VLANES word beats.
// Load results are sign- or zero-extended for scalars and gathered by lane
// for vectors.
// Optional feature: define LSU_MISALIGN_TRAP_EN to reject misaligned half,
// word and vector accesses with an error response. Without it, the
// misaligned low address bits are ignored.
module lsu_mem_sequencer #(
    parameter int VLANES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_store,
    input  logic [2:0]            req_width,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [32*VLANES-1:0]  req_vwdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [3:0]            mem_be,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [31:0]           resp_rdata,
    output logic [32*VLANES-1:0]  resp_vrdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [2:0] W_BS = 3'd0;
    localparam logic [2:0] W_HS = 3'd1;
    localparam logic [2:0] W_W  = 3'd2;
    localparam logic [2:0] W_BU = 3'd3;
    localparam logic [2:0] W_HU = 3'd4;
    localparam logic [2:0] W_V  = 3'd5;

    localparam logic [3:0] LAST_BEAT = 4'(VLANES - 1);

    logic [1:0]            state, state_n;
    logic                  store_q;
    logic [2:0]            width_q;
    logic [1:0]            off_q;
    logic [3:0]            beat_q;
    logic [32*VLANES-1:0]  vwdata_q;
    logic [32*VLANES-1:0]  vgather_q, vgather_n;
    logic                  accept, req_err, last_beat, beat_done;
    logic [3:0]            acc_be;
    logic [31:0]           acc_wdata;
    logic [31:0]           bshift, hshift, load_ext;

    assign accept    = req_valid && req_ready;
    assign beat_done = (state == S_WAIT) && mem_rvalid;
    assign last_beat = (width_q != W_V) || (beat_q == LAST_BEAT);

    // Decide whether a presented request is rejected before any bus beat
    always_comb begin
        req_err = (req_width == 3'd6) || (req_width == 3'd7);
`ifdef LSU_MISALIGN_TRAP_EN
        if (((req_width == W_HS) || (req_width == W_HU)) && req_addr[0])
            req_err = 1'b1;
        if (((req_width == W_W) || (req_width == W_V)) && (req_addr[1:0] != 2'b00))
            req_err = 1'b1;
`endif
    end

    // Byte enables and lane-replicated write data for the first beat
    always_comb begin
        acc_be    = 4'b1111;
        acc_wdata = req_wdata;
        case (req_width)
            W_BS, W_BU: begin
                acc_be    = 4'b0001 << req_addr[1:0];
                acc_wdata = {4{req_wdata[7:0]}};
            end
            W_HS, W_HU: begin
                acc_be    = 4'b0011 << {req_addr[1], 1'b0};
                acc_wdata = {2{req_wdata[15:0]}};
            end
            W_V: begin
                acc_wdata = req_vwdata[31:0];
            end
            default: begin
            end
        endcase
    end

    // Select and extend the addressed byte/half of the returned word
    always_comb begin
        bshift   = mem_rdata >> {off_q, 3'b000};
        hshift   = mem_rdata >> {off_q[1], 4'b0000};
        load_ext = mem_rdata;
        case (width_q)
            W_BS:    load_ext = {{24{bshift[7]}}, bshift[7:0]};
            W_BU:    load_ext = {24'd0, bshift[7:0]};
            W_HS:    load_ext = {{16{hshift[15]}}, hshift[15:0]};
            W_HU:    load_ext = {16'd0, hshift[15:0]};
            default: load_ext = mem_rdata;
        endcase
    end

    // Drop the returned word into the lane of the current vector beat
    always_comb begin
        vgather_n = vgather_q;
        for (int i = 0; i < VLANES; i++) begin
            if (beat_q == 4'(i))
                vgather_n[32*i +: 32] = mem_rdata;
        end
    end

    // Transaction state machine: IDLE -> ISSUE <-> WAIT -> RESP -> IDLE
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (accept) state_n = req_err ? S_RESP : S_ISSUE;
            S_ISSUE: if (mem_gnt) state_n = S_WAIT;
            S_WAIT:  if (mem_rvalid) state_n = last_beat ? S_RESP : S_ISSUE;
            default: state_n = S_IDLE;
        endcase
    end

    // State and control outputs, registered from the next-state value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            state      <= state_n;
            req_ready  <= (state_n == S_IDLE);
            mem_req    <= (state_n == S_ISSUE);
            mem_we     <= (state_n == S_ISSUE) && (accept ? req_store : store_q);
            resp_valid <= (state_n == S_RESP);
            resp_err   <= accept && req_err;
        end
    end

    // Request latching, per-beat bus fields and load result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            store_q     <= 1'b0;
            width_q     <= 3'd0;
            off_q       <= 2'd0;
            beat_q      <= 4'd0;
            vwdata_q    <= '0;
            vgather_q   <= '0;
            mem_addr    <= 32'd0;
            mem_be      <= 4'd0;
            mem_wdata   <= 32'd0;
            resp_rdata  <= 32'd0;
            resp_vrdata <= '0;
        end else begin
            if (accept && !req_err) begin
                store_q   <= req_store;
                width_q   <= req_width;
                off_q     <= req_addr[1:0];
                beat_q    <= 4'd0;
                vwdata_q  <= req_vwdata >> 32;
                mem_addr  <= {req_addr[31:2], 2'b00};
                mem_be    <= acc_be;
                mem_wdata <= acc_wdata;
            end
            if (beat_done) begin
                if (!store_q) begin
                    if (width_q == W_V) begin
                        vgather_q <= vgather_n;
                        if (last_beat)
                            resp_vrdata <= vgather_n;
                    end else begin
                        resp_rdata <= load_ext;
                    end
                end
                if (!last_beat) begin
                    beat_q    <= beat_q + 4'd1;
                    mem_addr  <= mem_addr + 32'd4;
                    mem_wdata <= vwdata_q[31:0];
                    vwdata_q  <= vwdata_q >> 32;
                end
            end
        end
    end

endmodule
